// File: rtl/pipes_pkg.sv
// Shared pipeline-stage types and sizing helpers for the 5-stage core.
// Holds the per-stage hazard controls and the pointer/count width rules used by pipe_stage_buf.
package pipes;

  typedef logic u1;

  typedef struct packed {
    u1 flush;
    u1 stall;
  } stage_ctl_t;

  // A DEPTH of 1 still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH x WIDTH storage for pipe_stage_buf: one synchronous write port and one
// asynchronous read port. There is no reset; the buffer masks stale entries.
module pipe_stage_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register: a small circular buffer with valid/ready on both sides,
// synchronous flush for redirects, and an explicit bubble output when empty.
module pipe_stage_buf
  import pipes::*;
#(
  parameter int               WIDTH  = 64,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_is_bubble,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  // Explicit wrap so any DEPTH works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign out_valid     = (r_count != '0);
  assign out_is_bubble = ~out_valid;
  assign in_ready      = (r_count < DEPTH_C) | (out_valid & out_ready);
  assign w_push        = in_valid & in_ready & ~flush;
  assign w_pop         = out_valid & out_ready & ~flush;
  assign out_data      = out_valid ? w_rdata : BUBBLE;
  assign count         = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  pipe_stage_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

`ifndef SYNTHESIS
  a_count_max : assert property (@(posedge clk) disable iff (reset) r_count <= DEPTH_C);
  a_no_push_full : assert property (@(posedge clk) disable iff (reset)
    !((r_count == DEPTH_C) && !out_ready && w_push));
  a_in_stable : assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready) |=> $stable(in_data));
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH 2, DEPTH 3, BUBBLE 8'h13) checked
// against a queue model under directed scenarios and randomized traffic.
module tb_pipe_stage_buf;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush     [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_data   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_data  [3];
  logic       out_bub   [3];
  logic [1:0] count     [3];

  int         dep [3] = '{2, 3, 2};
  logic [7:0] bub [3] = '{8'h00, 8'h00, 8'h13};

  logic [7:0] mq[$];
  logic [7:0] popq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         last_acc;
  int         maxc;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .BUBBLE(8'h00)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_is_bubble(out_bub[0]), .count(count[0]));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'h00)) u_d3 (
    .clk(clk), .reset(reset), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_is_bubble(out_bub[1]), .count(count[1]));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .BUBBLE(8'h13)) u_b13 (
    .clk(clk), .reset(reset), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_is_bubble(out_bub[2]), .count(count[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the queue model, then advance the model
  // to what the coming rising edge should do.
  task automatic step(input int s, input logic v, input logic [7:0] d, input logic r,
                      input logic f);
    int  sz;
    bit  exp_rdy;
    @(negedge clk);
    in_valid[s] = v; in_data[s] = d; out_ready[s] = r; flush[s] = f;
    #1;
    sz = mq.size();
    exp_rdy = (sz < dep[s]) || (sz > 0 && r);
    check("count", 32'(count[s]), 32'(sz));
    check("out_valid", 32'(out_valid[s]), 32'(sz > 0));
    check("out_is_bubble", 32'(out_bub[s]), 32'(sz == 0));
    check("out_data", 32'(out_data[s]), 32'((sz > 0) ? mq[0] : bub[s]));
    check("in_ready", 32'(in_ready[s]), 32'(exp_rdy));
    if (32'(count[s]) > maxc) maxc = 32'(count[s]);
    last_acc = v && exp_rdy && !f;
    if (f) mq.delete();
    else begin
      if (sz > 0 && r) popq.push_back(mq.pop_front());
      if (last_acc) mq.push_back(d);
    end
  endtask

  task automatic idle(input int s);
    step(s, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic       v;
    logic [7:0] d;
    bit         hold;
    int         idx;
    for (int i = 0; i < 3; i++) begin
      flush[i] = 0; in_valid[i] = 0; in_data[i] = 0; out_ready[i] = 0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(i);

    // Reset mid-stream.
    step(0, 1'b1, 8'hA1, 1'b0, 1'b0);
    step(0, 1'b1, 8'hA2, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; in_valid[0] = 1'b0;
    #1;
    check("rst_count", 32'(count[0]), 0);
    check("rst_out_valid", 32'(out_valid[0]), 0);
    check("rst_out_data", 32'(out_data[0]), 32'h00);
    check("rst_bubble", 32'(out_bub[0]), 1);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready[0]), 1);

    // Fill and stall, then full simultaneous push/pop.
    step(0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(0, 1'b1, 8'h33, 1'b0, 1'b0);
    check("stall_head", 32'(out_data[0]), 32'h11);
    check("stall_in_ready", 32'(in_ready[0]), 0);
    step(0, 1'b1, 8'h33, 1'b0, 1'b0);
    check("stall_count", 32'(count[0]), 2);
    step(0, 1'b1, 8'h33, 1'b1, 1'b0);
    check("full_pp_in_ready", 32'(in_ready[0]), 1);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("full_pp_count", 32'(count[0]), 2);
    check("full_pp_head1", 32'(out_data[0]), 32'h22);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("full_pp_head2", 32'(out_data[0]), 32'h33);
    idle(0);

    // Flush with concurrent push and pop.
    step(0, 1'b1, 8'h44, 1'b0, 1'b0);
    step(0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(0, 1'b1, 8'h66, 1'b1, 1'b1);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("flush_count", 32'(count[0]), 0);
    check("flush_bubble", 32'(out_bub[0]), 1);
    check("flush_data", 32'(out_data[0]), 32'h00);
    idle(0);

    // Wrap with DEPTH=3, out_ready every other cycle.
    popq.delete(); maxc = 0; idx = 0;
    for (int cyc = 0; cyc < 80 && popq.size() < 10; cyc++) begin
      step(1, idx < 10, 8'(idx + 1), cyc[0], 1'b0);
      if (last_acc) idx++;
    end
    check("wrap_n", 32'(popq.size()), 10);
    for (int i = 0; i < popq.size() && i < 10; i++) check("wrap_order", 32'(popq[i]), 32'(i + 1));
    check("wrap_maxc_le3", 32'(maxc <= 3), 1);
    idle(1);

    // Non-zero bubble value.
    idle(2);
    check("bub_data", 32'(out_data[2]), 32'h13);
    check("bub_valid", 32'(out_valid[2]), 0);
    step(2, 1'b1, 8'h7F, 1'b0, 1'b0);
    check("bub_same_cycle", 32'(out_data[2]), 32'h13);
    idle(2);
    check("bub_first_push", 32'(out_data[2]), 32'h7F);
    step(2, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Randomized traffic on every instance; upstream holds an unaccepted packet.
    for (int s = 0; s < 3; s++) begin
      hold = 0; v = 0; d = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        if (!hold) begin
          v = ($urandom_range(0, 3) != 0);
          d = 8'($urandom);
        end
        step(s, v, d, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        hold = v && !last_acc;
      end
      repeat (4) step(s, 1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_empty", 32'(count[s]), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register for the 5-stage core. Replaces the hard-wired IF/ID and ID/EX latches and the RESET_*/INSTR_MAINTAIN hazard encodings.
- Holds up to DEPTH in-flight packets (e.g. fetch_data_t, decode_data_t) in a small circular buffer with valid/ready handshakes on both sides.
- Provides a synchronous flush for branch/jump redirects.
- Drives an explicit bubble indication to the next stage whenever it has nothing to present.

Parameters:
- WIDTH, 64: payload width in bits, normally $bits of a pipes stage struct.
- DEPTH, 2: number of buffer entries, at least 1, need not be a power of two.
- BUBBLE, '0: WIDTH-bit value driven on out_data while the buffer is empty.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous discard of all contents (redirect from the hazard unit).
- in_valid  input  1  upstream presents a packet.
- in_ready  output  1  stage can accept the packet this cycle.
- in_data  input  WIDTH  upstream packet.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head this cycle; 0 means stall.
- out_data  output  WIDTH  head entry, or BUBBLE when empty.
- out_is_bubble  output  1  equals !out_valid; feeds the is_bubble field.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid=0, out_is_bubble=1, out_data=BUBBLE.
  - in_ready=1 once reset is deasserted.
- Definitions:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - Both are evaluated at the rising edge.
- in_ready = (count < DEPTH) | (out_valid & out_ready). This is combinational: a full buffer accepts a new packet in the same cycle its head is consumed.
- out_valid = (count != 0). out_data = mem[rd_ptr] when valid, else BUBBLE. out_data is never combinationally derived from in_data; there is no fall-through.
- Latency:
  - A packet pushed at edge k is visible on out_data after edge k.
  - At least one cycle from in to out; full throughput of 1 packet/cycle for any DEPTH.
- Pointers advance by 1 on push (wr_ptr) and pop (rd_ptr). Each wraps from DEPTH-1 to 0, with no power-of-two assumption.
- count update rule:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, whether empty-adjacent or full.
- Full (count==DEPTH) with out_ready=0:
  - in_ready=0.
  - Upstream must hold in_data/in_valid; the buffer contents are unchanged.
- Empty with in_valid=1: push only. out_valid does not assert until the next cycle.
- Flush:
  - Highest priority after reset.
  - At the edge: count=0 and wr_ptr=rd_ptr=0.
  - The concurrent in_data is discarded, and no pop is counted even if out_ready=1.
  - The cycle after the flush: out_valid=0, out_data=BUBBLE.
- Storage writes occur only on push. Stale entries are never exposed because out_data is masked by out_valid.
- Assertions (verification only):
  - count <= DEPTH.
  - No push when count==DEPTH && !out_ready.
  - in_data stable while in_valid && !in_ready.

Decomposition:
- Package pipes adds:
  - stage_ctl_t {u1 flush; u1 stall;}: the per-stage hazard outputs, replacing reset_t/instr_FETCH_t.
  - localparam function helpers for the pointer width ($clog2(DEPTH) with a minimum of 1).
- One sub-module, pipe_stage_mem: a DEPTH x WIDTH register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata), reset-free.
- pipe_stage_buf holds the pointers, count, handshake logic and bubble muxing.

Test Plan (WIDTH=8, DEPTH=2, BUBBLE=8'h00 unless noted):
- Reset mid-stream: push 8'hA1, 8'hA2, then assert reset for 1 cycle -> count=0, out_valid=0, out_data=8'h00, in_ready=1 immediately after release.
- Fill and stall: out_ready=0, push 8'h11, 8'h22 -> count=2, in_ready=0, out_data=8'h11. A held 8'h33 is not accepted until out_ready=1.
- Full simultaneous push/pop: count=2, out_ready=1, in_valid=1 with 8'h33 -> that edge pops 8'h11 and pushes 8'h33, count stays 2. The following heads are 8'h22, then 8'h33.
- Wrap with non-power-of-two DEPTH=3: stream 8'h01..8'h0A with out_ready=1 pulsed every other cycle -> output order 01..0A with no loss or duplication, and count never exceeds 3.
- Flush with concurrent push/pop: count=2 (8'h44, 8'h55), flush=1, in_valid=1 (8'h66), out_ready=1 -> next cycle count=0, out_is_bubble=1. 8'h66 never appears on out_data.
- Bubble value: BUBBLE=8'h13 (nop low byte), empty buffer -> out_data=8'h13 and out_valid=0. The first push of 8'h7F shows out_data=8'h7F one cycle later.
